// File: rtl/pe_vec.sv
// Vectoring-mode CORDIC processing element: drives Y to zero and
// produces the gain-compensated magnitude plus the direction word.
module pe_vec #(
    parameter int BITWIDTH   = 18,
    parameter int CORDIC_NUM = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic signed [BITWIDTH-1:0] X_i,
    input  logic signed [BITWIDTH-1:0] Y_i,
    output logic                       out_valid,
    output logic signed [BITWIDTH-1:0] R_o,
    output logic [CORDIC_NUM-1:0]      angle_d_o,
    output logic                       flip_o
);

    // One guard bit absorbs the CORDIC gain growth.
    localparam int W  = BITWIDTH + 1;
    localparam int PW = W + 15;
    localparam logic signed [14:0] K = 15'sb010011011011101;

    typedef struct packed {
        logic                  flip;
        logic [CORDIC_NUM-1:0] dir;
        logic signed [W-1:0]   x;
        logic signed [W-1:0]   y;
    } stage_t;

    // Micro-rotations lo..hi; the sign of Y picks each direction bit.
    function automatic stage_t rotate(input stage_t s, input int lo,
                                      input int hi);
        stage_t              r;
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic signed [W-1:0] t;
        r = s;
        x = s.x;
        y = s.y;
        for (int k = 0; k < CORDIC_NUM; k++) begin
            if (k >= lo && k <= hi) begin
                t = x;
                if (y[W-1]) begin
                    r.dir[k] = 1'b1;
                    x = x - (y >>> k);
                    y = y + (t >>> k);
                end else begin
                    r.dir[k] = 1'b0;
                    x = x + (y >>> k);
                    y = y - (t >>> k);
                end
            end
        end
        r.x = x;
        r.y = y;
        return r;
    endfunction

    logic signed [W-1:0]  x_ext;
    logic signed [W-1:0]  y_ext;
    logic signed [W-1:0]  x2;
    logic signed [PW-1:0] prod;
    stage_t               pre;
    stage_t               s0_d, s1_d, s2_d;
    stage_t               s0_q, s1_q, s2_q;
    logic                 v0, v1, v2;
    logic                 unused_bits;

    assign x_ext = {X_i[BITWIDTH-1], X_i};
    assign y_ext = {Y_i[BITWIDTH-1], Y_i};

    // Fold the left half-plane onto the right so convergence holds.
    always_comb begin
        pre      = '0;
        pre.flip = X_i[BITWIDTH-1];
        pre.x    = pre.flip ? -x_ext : x_ext;
        pre.y    = pre.flip ? -y_ext : y_ext;
    end

    // Split the 14 micro-rotations over three pipeline stages.
    always_comb begin
        s0_d = rotate(pre, 0, 3);
        s1_d = rotate(s0_q, 4, 8);
        s2_d = rotate(s1_q, 9, 13);
    end

    // Data and valid bits advance every cycle; bubbles simply flow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= '0;
            s1_q <= '0;
            s2_q <= '0;
            v0   <= 1'b0;
            v1   <= 1'b0;
            v2   <= 1'b0;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            v0   <= in_valid;
            v1   <= v0;
            v2   <= v1;
        end
    end

    assign x2   = s2_q.x;
    assign prod = PW'(x2) * PW'(K);

    assign unused_bits = ^{s2_q.y, prod[13:0], prod[PW-1:BITWIDTH+14]};

    // Output stage scales by 1/gain and holds until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            R_o       <= '0;
            angle_d_o <= '0;
            flip_o    <= 1'b0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                R_o       <= prod[BITWIDTH+13:14];
                angle_d_o <= s2_q.dir;
                flip_o    <= s2_q.flip;
            end
        end
    end

endmodule

// File: tb/tb_pe_vec.sv
// Self-checking bench for pe_vec: directed scenarios, random
// back-to-back traffic and mid-flight reset against a math model.
module tb_pe_vec;

    localparam int BW = 18;
    localparam int CN = 14;
    localparam int M  = 65535;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic signed [BW-1:0] X_i;
    logic signed [BW-1:0] Y_i;
    logic                 out_valid;
    logic signed [BW-1:0] R_o;
    logic [CN-1:0]        angle_d_o;
    logic                 flip_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_vec #(.BITWIDTH(BW), .CORDIC_NUM(CN)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .X_i(X_i),
        .Y_i(Y_i),
        .out_valid(out_valid),
        .R_o(R_o),
        .angle_d_o(angle_d_o),
        .flip_o(flip_o)
    );

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: pre-negate, 14 CORDIC steps, floor(x*9949/2^14).
    function automatic void model(input int xi, input int yi,
                                  output int r, output logic [13:0] a,
                                  output logic f);
        longint x, y, t;
        f = (xi < 0);
        x = f ? -longint'(xi) : longint'(xi);
        y = f ? -longint'(yi) : longint'(yi);
        a = '0;
        for (int k = 0; k < 14; k++) begin
            t = x;
            if (y < 0) begin
                a[k] = 1'b1;
                x = x - (y >>> k);
                y = y + (t >>> k);
            end else begin
                x = x + (y >>> k);
                y = y - (t >>> k);
            end
        end
        r = int'((x * 64'sd9949) >>> 14);
    endfunction

    // Rotation PE stand-in: replay direction bits on (0,1000).
    function automatic void rot_apply(input logic [13:0] a,
                                      output int rx, output int ry);
        longint x, y, t;
        x = 0;
        y = 1000;
        for (int k = 0; k < 14; k++) begin
            t = x;
            if (a[k]) begin
                x = x - (y >>> k);
                y = y + (t >>> k);
            end else begin
                x = x + (y >>> k);
                y = y - (t >>> k);
            end
        end
        rx = int'((x * 64'sd9949) >>> 14);
        ry = int'((y * 64'sd9949) >>> 14);
    endfunction

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        X_i      = '0;
        Y_i      = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (R_o !== '0) begin
            errors++;
            $display("FAIL reset_R got %0d want 0", R_o);
        end
        checks++;
        if (angle_d_o !== '0) begin
            errors++;
            $display("FAIL reset_angle got %h want 0", angle_d_o);
        end
        checks++;
        if (flip_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flip got %b want 0", flip_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_scenarios;
        int   xs[5]  = '{3000, -3000, 1000, 0, 0};
        int   ys[5]  = '{4000, 4000, 0, 0, -2000};
        int   nom[5] = '{5000, 5000, 1000, 0, 2000};
        int   tol[5] = '{4, 4, 2, 0, 8};
        logic ef[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic ea0[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int          er, rx, ry, early;
        logic [13:0] ea;
        logic        efl;
        for (int i = 0; i < 5; i++) begin
            model(xs[i], ys[i], er, ea, efl);
            in_valid = 1'b1;
            X_i = BW'(xs[i]);
            Y_i = BW'(ys[i]);
            early = 0;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                if (out_valid !== 1'b0) early++;
            end
            checks++;
            if (early != 0) begin
                errors++;
                $display("FAIL scen%0d_early_valid got %0d want 0", i, early);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL scen%0d_latency got %b want 1", i, out_valid);
            end
            checks++;
            if (int'(R_o) != er) begin
                errors++;
                $display("FAIL scen%0d_R got %0d want %0d", i, R_o, er);
            end
            checks++;
            if (angle_d_o !== ea) begin
                errors++;
                $display("FAIL scen%0d_angle got %h want %h", i, angle_d_o, ea);
            end
            checks++;
            if (flip_o !== efl || flip_o !== ef[i]) begin
                errors++;
                $display("FAIL scen%0d_flip got %b want %b", i, flip_o, ef[i]);
            end
            checks++;
            if (iabs(int'(R_o) - nom[i]) > tol[i]) begin
                errors++;
                $display("FAIL scen%0d_R_tol got %0d want %0d+/-%0d",
                         i, R_o, nom[i], tol[i]);
            end
            checks++;
            if (angle_d_o[0] !== ea0[i]) begin
                errors++;
                $display("FAIL scen%0d_d0 got %b want %b", i, angle_d_o[0], ea0[i]);
            end
            if (i == 2) begin
                checks++;
                if (angle_d_o[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL scen2_d1 got %b want 1", angle_d_o[1]);
                end
                rot_apply(angle_d_o, rx, ry);
                checks++;
                if (iabs(rx) > 3 || iabs(ry - 1000) > 3) begin
                    errors++;
                    $display("FAIL scen2_rotate got (%0d,%0d) want (0,1000)+/-3",
                             rx, ry);
                end
            end
            if (i == 3) begin
                checks++;
                if (angle_d_o !== 14'h0000) begin
                    errors++;
                    $display("FAIL scen3_zero_angle got %h want 0000", angle_d_o);
                end
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || int'(R_o) != er) begin
                errors++;
                $display("FAIL scen%0d_pulse_hold got v=%b R=%0d want v=0 R=%0d",
                         i, out_valid, R_o, er);
            end
        end
    endtask

    task automatic test_back_to_back;
        int          qr[$];
        logic [13:0] qa[$];
        logic        qf[$];
        int          er, xr, yr, seen, lr;
        logic [13:0] ea, la;
        logic        efl, lf;
        seen = 0;
        lr = 0;
        la = '0;
        lf = 1'b0;
        for (int c = 0; c < 18; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (c != 4 + seen || qr.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_timing got cycle %0d want %0d", c, 4 + seen);
                end
                if (qr.size() != 0) begin
                    er = qr.pop_front();
                    ea = qa.pop_front();
                    efl = qf.pop_front();
                    checks++;
                    if (int'(R_o) != er || angle_d_o !== ea || flip_o !== efl) begin
                        errors++;
                        $display("FAIL b2b_result%0d got R=%0d a=%h f=%b want R=%0d a=%h f=%b",
                                 seen, R_o, angle_d_o, flip_o, er, ea, efl);
                    end
                end
                seen++;
                lr = int'(R_o);
                la = angle_d_o;
                lf = flip_o;
            end else if (seen > 0) begin
                checks++;
                if (int'(R_o) != lr || angle_d_o !== la || flip_o !== lf) begin
                    errors++;
                    $display("FAIL b2b_hold got R=%0d a=%h f=%b want R=%0d a=%h f=%b",
                             R_o, angle_d_o, flip_o, lr, la, lf);
                end
            end
            if (c < 8) begin
                xr = int'($urandom_range(0, 2 * M)) - M;
                yr = int'($urandom_range(0, 2 * M)) - M;
                model(xr, yr, er, ea, efl);
                qr.push_back(er);
                qa.push_back(ea);
                qf.push_back(efl);
                in_valid = 1'b1;
                X_i = BW'(xr);
                Y_i = BW'(yr);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (seen != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d want 8", seen);
        end
    endtask

    task automatic test_reset_midflight;
        int          er, stray;
        logic [13:0] ea;
        logic        efl;
        in_valid = 1'b1;
        X_i = BW'(12345);
        Y_i = BW'(-2222);
        @(negedge clk);
        X_i = BW'(-777);
        Y_i = BW'(31000);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || R_o !== '0 || angle_d_o !== '0
            || flip_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear got v=%b R=%0d a=%h f=%b want all 0",
                     out_valid, R_o, angle_d_o, flip_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL midrst_stray_valid got %0d want 0", stray);
        end
        model(-40000, -50000, er, ea, efl);
        in_valid = 1'b1;
        X_i = BW'(-40000);
        Y_i = BW'(-50000);
        stray = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid !== 1'b0) stray++;
        end
        @(negedge clk);
        checks++;
        if (stray != 0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_latency got early=%0d v=%b want early=0 v=1",
                     stray, out_valid);
        end
        checks++;
        if (int'(R_o) != er || angle_d_o !== ea || flip_o !== efl) begin
            errors++;
            $display("FAIL midrst_result got R=%0d a=%h f=%b want R=%0d a=%h f=%b",
                     R_o, angle_d_o, flip_o, er, ea, efl);
        end
    endtask

    initial begin
        test_reset();
        test_scenarios();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
